// File: rtl/tmds_word_decoder.sv
// tmds_word_decoder
// One TMDS channel front end. It shifts in the recovered serial bit stream
// (LSB first), finds the 10-bit word boundary by hunting for control tokens
// and slipping one bit at a time, then decodes each aligned word into either
// an 8-bit video byte or a 2-bit control value.
module tmds_word_decoder #(
    parameter int CTRL_RUN      = 8,
    parameter int SEARCH_WORDS  = 1024,
    parameter int TIMEOUT_WORDS = 2048
) (
    input  logic       hdmi_bit_clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic       word_valid,
    output logic       de,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic [3:0] bit_phase
);

    localparam int RUN_W   = $clog2(CTRL_RUN + 1);
    localparam int WORDS_W = $clog2(SEARCH_WORDS + 1);
    localparam int TO_W    = $clog2(TIMEOUT_WORDS + 1);

    // "_LAST" values: the counter value that, when one more word arrives,
    // reaches the threshold.
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(CTRL_RUN - 1);
    localparam logic [RUN_W-1:0]   RUN_MAX    = RUN_W'(CTRL_RUN);
    localparam logic [WORDS_W-1:0] WORDS_LAST = WORDS_W'(SEARCH_WORDS - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_WORDS - 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // The newest bit lives in the MSB; together with serial_in this forms a word.
    logic [8:0]         sr_reg;
    logic [3:0]         bit_cnt_reg;
    logic [9:0]         raw_reg;
    logic               raw_stb_reg;
    logic               slip_pend_reg;
    logic [3:0]         bit_phase_reg;

    state_t             state_reg, state_next;
    logic [RUN_W-1:0]   run_reg, run_next;
    logic [WORDS_W-1:0] words_reg, words_next;
    logic [TO_W-1:0]    to_reg, to_next;
    logic               slip_req;

    logic               tok_hit;
    logic [1:0]         tok_ctrl;
    logic [7:0]         d_byte;
    logic [7:0]         dec_byte;
    logic               emit;

    logic               word_valid_reg;
    logic               de_reg;
    logic [7:0]         data_reg;
    logic [1:0]         ctrl_reg;
    logic               locked_reg;

    // Deserialiser: shift every bit, capture a word every 10th bit, and
    // apply a pending slip by holding the bit counter for one cycle.
    always_ff @(posedge hdmi_bit_clk) begin
        if (reset) begin
            sr_reg        <= '0;
            bit_cnt_reg   <= '0;
            raw_reg       <= '0;
            raw_stb_reg   <= 1'b0;
            slip_pend_reg <= 1'b0;
            bit_phase_reg <= '0;
        end else begin
            sr_reg      <= {serial_in, sr_reg[8:1]};
            raw_stb_reg <= 1'b0;
            if (bit_cnt_reg == 4'd9) begin
                // Capture edge: a slip is never applied here, it waits.
                raw_reg     <= {serial_in, sr_reg};
                raw_stb_reg <= 1'b1;
                bit_cnt_reg <= '0;
            end else if (slip_pend_reg) begin
                slip_pend_reg <= 1'b0;
                bit_phase_reg <= (bit_phase_reg == 4'd9) ? 4'd0 : bit_phase_reg + 4'd1;
            end else begin
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
            if (slip_req) begin
                slip_pend_reg <= 1'b1;
            end
        end
    end

    // Recognise the four control tokens.
    always_comb begin
        tok_hit  = 1'b1;
        tok_ctrl = 2'b00;
        case (raw_reg)
            10'b1101010100: tok_ctrl = 2'b00;
            10'b0010101011: tok_ctrl = 2'b01;
            10'b0101010100: tok_ctrl = 2'b10;
            10'b1010101011: tok_ctrl = 2'b11;
            default:        tok_hit  = 1'b0;
        endcase
    end

    // TMDS data decode: undo the optional inversion, then the XOR/XNOR chain.
    assign d_byte      = raw_reg[9] ? ~raw_reg[7:0] : raw_reg[7:0];
    assign dec_byte[0] = d_byte[0];
    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_dec
            assign dec_byte[gi] = raw_reg[8] ? (d_byte[gi] ^ d_byte[gi-1])
                                             : ~(d_byte[gi] ^ d_byte[gi-1]);
        end
    endgenerate

    // Alignment FSM state and counters.
    always_ff @(posedge hdmi_bit_clk) begin
        if (reset) begin
            state_reg <= SEARCH;
            run_reg   <= '0;
            words_reg <= '0;
            to_reg    <= '0;
        end else begin
            state_reg <= state_next;
            run_reg   <= run_next;
            words_reg <= words_next;
            to_reg    <= to_next;
        end
    end

    // Alignment FSM next state: count token runs while searching, request a
    // slip after a fruitless search window, and time out a silent lock.
    always_comb begin
        state_next = state_reg;
        run_next   = run_reg;
        words_next = words_reg;
        to_next    = to_reg;
        slip_req   = 1'b0;
        if (raw_stb_reg) begin
            case (state_reg)
                SEARCH: begin
                    if (tok_hit) begin
                        if (run_reg >= RUN_LAST) begin
                            state_next = LOCKED;
                            run_next   = RUN_MAX;
                            to_next    = '0;
                            words_next = '0;
                        end else begin
                            run_next = run_reg + 1'b1;
                        end
                    end else begin
                        run_next = '0;
                    end
                    if (state_next == SEARCH) begin
                        if (words_reg >= WORDS_LAST) begin
                            slip_req   = 1'b1;
                            words_next = '0;
                            run_next   = '0;
                        end else begin
                            words_next = words_reg + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (tok_hit) begin
                        to_next = '0;
                    end else if (to_reg >= TO_LAST) begin
                        state_next = SEARCH;
                        run_next   = '0;
                        words_next = '0;
                        to_next    = '0;
                    end else begin
                        to_next = to_reg + 1'b1;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    // A word is emitted when it is seen in (or brings us into) LOCKED.
    assign emit = raw_stb_reg && (state_next == LOCKED);

    // Registered outputs; decoded fields only move on emitted words so they
    // hold their last values across a lock loss.
    always_ff @(posedge hdmi_bit_clk) begin
        if (reset) begin
            word_valid_reg <= 1'b0;
            de_reg         <= 1'b0;
            data_reg       <= '0;
            ctrl_reg       <= '0;
            locked_reg     <= 1'b0;
        end else begin
            word_valid_reg <= emit;
            locked_reg     <= (state_next == LOCKED);
            if (emit) begin
                if (tok_hit) begin
                    de_reg   <= 1'b0;
                    ctrl_reg <= tok_ctrl;
                end else begin
                    de_reg   <= 1'b1;
                    data_reg <= dec_byte;
                end
            end
        end
    end

    assign word_valid = word_valid_reg;
    assign de         = de_reg;
    assign data       = data_reg;
    assign ctrl       = ctrl_reg;
    assign locked     = locked_reg;
    assign bit_phase  = bit_phase_reg;

endmodule

// File: tb/tb_tmds_word_decoder.sv
// tb_tmds_word_decoder
// Drives serial TMDS words into the decoder and checks every emitted word
// against a queue of expected results filled as words are sent.
module tb_tmds_word_decoder;

    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] TOK1 = 10'b0010101011;
    localparam logic [9:0] TOK2 = 10'b0101010100;
    localparam logic [9:0] TOK3 = 10'b1010101011;

    logic       hdmi_bit_clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic       word_valid;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       locked;
    logic [3:0] bit_phase;

    tmds_word_decoder #(
        .CTRL_RUN      (8),
        .SEARCH_WORDS  (16),
        .TIMEOUT_WORDS (2048)
    ) dut (
        .hdmi_bit_clk (hdmi_bit_clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .word_valid   (word_valid),
        .de           (de),
        .data         (data),
        .ctrl         (ctrl),
        .locked       (locked),
        .bit_phase    (bit_phase)
    );

    always #5 hdmi_bit_clk = ~hdmi_bit_clk;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          wsr          = 0;   // whole words sent since reset
    int          lock_word    = -1;
    int          unlock_word  = -1;
    int          lock_falls   = 0;
    int          n_words_seen = 0;
    logic        locked_prev  = 1'b0;
    logic        sb_en        = 1'b1;
    logic [7:0]  exp_data     = 8'h00;
    logic [1:0]  exp_ctrl     = 2'b00;
    logic [10:0] sb_q[$];           // {de, data, ctrl}

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference TMDS encoder (data period), inversion chosen from byte bits.
    function automatic logic [9:0] tmds_encode(input logic [7:0] b);
        int         n1;
        logic       xn;
        logic       inv;
        logic [8:0] q;
        n1   = $countones(b);
        xn   = (n1 > 4) || (n1 == 4 && b[0] == 1'b0);
        q[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xn ? ~(q[i-1] ^ b[i]) : (q[i-1] ^ b[i]);
        end
        q[8] = ~xn;
        inv  = b[1] ^ b[6];
        return {inv, q[8], inv ? ~q[7:0] : q[7:0]};
    endfunction

    task automatic push_token(input logic [1:0] c);
        exp_ctrl = c;
        sb_q.push_back({1'b0, exp_data, c});
    endtask

    task automatic push_data(input logic [7:0] b);
        exp_data = b;
        sb_q.push_back({1'b1, b, exp_ctrl});
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        @(negedge hdmi_bit_clk);
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) begin
            send_bit(w[i]);
        end
        wsr++;
    endtask

    // One-cycle reset; must be called on a falling edge.
    task automatic do_reset();
        reset     = 1'b1;
        serial_in = 1'b0;
        @(negedge hdmi_bit_clk);
        reset     = 1'b0;
        wsr       = 0;
        exp_data  = 8'h00;
        exp_ctrl  = 2'b00;
        lock_word = -1;
    endtask

    task automatic check_all_zero(input string pfx);
        check_value({pfx, "_word_valid"}, 32'(word_valid), 32'd0);
        check_value({pfx, "_de"},         32'(de),         32'd0);
        check_value({pfx, "_data"},       32'(data),       32'd0);
        check_value({pfx, "_ctrl"},       32'(ctrl),       32'd0);
        check_value({pfx, "_locked"},     32'(locked),     32'd0);
        check_value({pfx, "_bit_phase"},  32'(bit_phase),  32'd0);
    endtask

    // Monitor: sample just after the rising edge, track lock edges and
    // compare every emitted word against the scoreboard.
    always @(posedge hdmi_bit_clk) begin
        logic [10:0] exp_e;
        #1;
        if (locked && !locked_prev) lock_word = wsr;
        if (!locked && locked_prev) begin
            unlock_word = wsr;
            lock_falls++;
        end
        locked_prev = locked;
        if (word_valid && sb_en) begin
            if (sb_q.size() == 0) begin
                check_value("sb_unexpected_word", 32'd1, 32'd0);
            end else begin
                exp_e = sb_q.pop_front();
                n_words_seen++;
                $display("word %0d: de=%0b data=%02h ctrl=%0d (expect de=%0b data=%02h ctrl=%0d)",
                         n_words_seen, de, data, ctrl, exp_e[10], exp_e[9:2], exp_e[1:0]);
                check_value("sb_word", 32'({de, data, ctrl}), 32'(exp_e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          falls0;
        logic [7:0]  b;
        logic [9:0]  w;

        reset     = 1'b1;
        serial_in = 1'b0;
        repeat (3) @(negedge hdmi_bit_clk);
        do_reset();
        check_all_zero("reset");

        // Aligned token stream: lock on the 8th token.
        for (int k = 1; k <= 20; k++) begin
            if (k >= 8) push_token(2'b00);
            send_word(TOK0);
        end
        check_value("t1_lock_word", 32'(lock_word), 32'd8);
        check_value("t1_locked",    32'(locked),    32'd1);
        check_value("t1_bit_phase", 32'(bit_phase), 32'd0);
        check_value("t1_ctrl",      32'(ctrl),      32'd0);
        check_value("t1_de",        32'(de),        32'd0);

        // Fixed data words, then a token to restart the timeout.
        push_data(8'h00);
        send_word(10'b0100000000);
        push_data(8'hFF);
        send_word(10'b0011111111);
        push_token(2'b00);
        send_word(TOK0);

        // Timeout: 2048 data words, the last one drops lock and is not emitted.
        base = wsr;
        for (int k = 1; k <= 2048; k++) begin
            b = 8'($urandom_range(0, 255));
            if (k < 2048) push_data(b);
            send_word(tmds_encode(b));
        end
        repeat (2) @(negedge hdmi_bit_clk);
        check_value("t4_sb_drained",   32'(sb_q.size()), 32'd0);
        check_value("t4_locked",       32'(locked),      32'd0);
        check_value("t4_word_valid",   32'(word_valid),  32'd0);
        check_value("t4_unlock_word",  32'(unlock_word), 32'(base + 2048));
        check_value("t4_data_hold",    32'(data),        32'(exp_data));

        // Reset mid-word while locked, then relock.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            if (k >= 8) push_token(2'b01);
            send_word(TOK1);
        end
        push_data(8'h5A);
        send_word(tmds_encode(8'h5A));
        w = TOK1;
        for (int i = 0; i < 4; i++) send_bit(w[i]);
        check_value("t5_locked_before", 32'(locked), 32'd1);
        do_reset();
        check_all_zero("t5_reset");
        check_value("t5_sb_drained", 32'(sb_q.size()), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            if (k >= 8) push_token(2'b10);
            send_word(TOK2);
        end
        check_value("t5_relock_word", 32'(lock_word), 32'd8);

        // Miniature frame: blanking tokens and a 0..255 video ramp per line.
        falls0 = lock_falls;
        for (int ln = 0; ln < 4; ln++) begin
            for (int k = 0; k < 12; k++) begin
                if (k[0]) begin
                    push_token(2'b01);
                    send_word(TOK1);
                end else begin
                    push_token(2'b00);
                    send_word(TOK0);
                end
            end
            for (int px = 0; px < 256; px++) begin
                push_data(8'(px));
                send_word(tmds_encode(8'(px)));
            end
        end
        for (int k = 0; k < 4; k++) begin
            push_token(2'b10);
            send_word(TOK2);
        end
        repeat (2) @(negedge hdmi_bit_clk);
        check_value("t6_sb_drained", 32'(sb_q.size()), 32'd0);
        check_value("t6_locked",     32'(locked),      32'd1);
        check_value("t6_lock_falls", 32'(lock_falls),  32'(falls0));

        // Stream offset by 3 bits: seven slips before lock.
        do_reset();
        sb_en = 1'b0;
        w = TOK0;
        for (int i = 3; i < 10; i++) send_bit(w[i]);
        for (int n = 0; n < 300 && !locked; n++) begin
            send_word(TOK0);
        end
        check_value("t2_locked",    32'(locked),    32'd1);
        check_value("t2_bit_phase", 32'(bit_phase), 32'd7);
        sb_en = 1'b1;
        push_token(2'b00);           // word still in flight when lock was seen
        for (int k = 0; k < 4; k++) begin
            push_token(2'b11);
            send_word(TOK3);
        end
        repeat (2) @(negedge hdmi_bit_clk);
        check_value("t2_sb_drained",   32'(sb_q.size()), 32'd0);
        check_value("t2_phase_frozen", 32'(bit_phase),   32'd7);
        check_value("t2_ctrl",         32'(ctrl),        32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
